// File: rtl/ppu_ri_master_if.sv
// CPU-side request bus, DMA memory port and PPU register interface of ppu_ri_master.
// The master modport is the block itself; slave is the CPU/memory/PPU environment.
interface ppu_ri_master_if;
  logic        req;
  logic [15:0] req_a;
  logic        req_r_nw;
  logic [7:0]  req_din;
  logic [7:0]  req_dout;
  logic        req_rdy;
  logic        busy;
  logic        dma_active;
  logic [15:0] mem_a;
  logic        mem_rd;
  logic [7:0]  mem_din;
  logic [2:0]  ri_sel;
  logic        ri_ncs;
  logic        ri_r_nw;
  logic [7:0]  ri_din;
  logic [7:0]  ri_dout;

  modport master (
    input  req, req_a, req_r_nw, req_din, mem_din, ri_dout,
    output req_dout, req_rdy, busy, dma_active, mem_a, mem_rd,
           ri_sel, ri_ncs, ri_r_nw, ri_din
  );

  modport slave (
    output req, req_a, req_r_nw, req_din, mem_din, ri_dout,
    input  req_dout, req_rdy, busy, dma_active, mem_a, mem_rd,
           ri_sel, ri_ncs, ri_r_nw, ri_din
  );
endinterface

// File: rtl/ppu_ri_master.sv
// Bridges CPU accesses onto the PPU register interface with fixed chip-select timing,
// and runs 256-byte sprite DMA from memory into PPU register 4.
module ppu_ri_master #(
  parameter int unsigned CS_LOW_CYCLES  = 4,
  parameter int unsigned CS_HIGH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  ppu_ri_master_if.master  bus_io
);

  typedef enum logic [2:0] {StIdle, StCsLow, StCsHigh, StDmaRd, StDmaCap} state_e;

  localparam logic [3:0] LowLast  = 4'(CS_LOW_CYCLES - 1);
  localparam logic [3:0] HighLast = 4'(CS_HIGH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic        last_q, last_d;
  logic        dma_q, dma_d;
  logic [7:0]  page_q, page_d;
  logic [2:0]  ri_sel_q, ri_sel_d;
  logic        ri_ncs_q, ri_ncs_d;
  logic        ri_r_nw_q, ri_r_nw_d;
  logic [7:0]  ri_din_q, ri_din_d;
  logic [7:0]  req_dout_q, req_dout_d;
  logic        req_rdy_q, req_rdy_d;
  logic        busy_q, busy_d;
  logic [15:0] mem_a_q, mem_a_d;
  logic        mem_rd_q, mem_rd_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    last_d     = last_q;
    dma_d      = dma_q;
    page_d     = page_q;
    ri_sel_d   = ri_sel_q;
    ri_r_nw_d  = ri_r_nw_q;
    ri_din_d   = ri_din_q;
    req_dout_d = req_dout_q;
    req_rdy_d  = 1'b0;
    mem_a_d    = mem_a_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.req) begin
          if (bus_io.req_a[15:13] == 3'b001) begin
            state_d   = StCsLow;
            cnt_d     = LowLast;
            ri_sel_d  = bus_io.req_a[2:0];
            ri_r_nw_d = bus_io.req_r_nw;
            ri_din_d  = bus_io.req_din;
          end else if (bus_io.req_a == 16'h4014 && !bus_io.req_r_nw) begin
            state_d = StDmaRd;
            dma_d   = 1'b1;
            last_d  = 1'b0;
            page_d  = bus_io.req_din;
            idx_d   = 8'h00;
            mem_a_d = {bus_io.req_din, 8'h00};
          end else begin
            req_rdy_d  = 1'b1;
            req_dout_d = 8'h00;
          end
        end
      end
      StCsLow: begin
        if (cnt_q == 4'd0) begin
          state_d = StCsHigh;
          cnt_d   = HighLast;
          if (!dma_q) begin
            req_rdy_d = 1'b1;
            if (ri_r_nw_q) req_dout_d = bus_io.ri_dout;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StCsHigh: begin
        if (cnt_q == 4'd0) begin
          if (dma_q && !last_q) begin
            state_d = StDmaRd;
            idx_d   = idx_q + 8'd1;
            mem_a_d = {page_q, idx_q + 8'd1};
          end else begin
            state_d = StIdle;
            idx_d   = 8'h00;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDmaRd: state_d = StDmaCap;
      StDmaCap: begin
        state_d   = StCsLow;
        cnt_d     = LowLast;
        ri_din_d  = bus_io.mem_din;
        ri_sel_d  = 3'h4;
        ri_r_nw_d = 1'b0;
        // Separate flag so the 8-bit index can wrap without a 257th byte.
        last_d    = (idx_q == 8'hFF);
      end
      default: state_d = StIdle;
    endcase

    // DMA completes on the final CS_HIGH clock of the last byte.
    if (dma_q && last_q && state_d == StCsHigh && cnt_d == 4'd0) req_rdy_d = 1'b1;
    if (state_d == StIdle) dma_d = 1'b0;

    ri_ncs_d = (state_d != StCsLow);
    busy_d   = (state_d != StIdle);
    mem_rd_d = (state_d == StDmaRd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      idx_q      <= 8'h00;
      last_q     <= 1'b0;
      dma_q      <= 1'b0;
      page_q     <= 8'h00;
      ri_sel_q   <= 3'd0;
      ri_ncs_q   <= 1'b1;
      ri_r_nw_q  <= 1'b1;
      ri_din_q   <= 8'h00;
      req_dout_q <= 8'h00;
      req_rdy_q  <= 1'b0;
      busy_q     <= 1'b0;
      mem_a_q    <= 16'h0000;
      mem_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      dma_q      <= dma_d;
      page_q     <= page_d;
      ri_sel_q   <= ri_sel_d;
      ri_ncs_q   <= ri_ncs_d;
      ri_r_nw_q  <= ri_r_nw_d;
      ri_din_q   <= ri_din_d;
      req_dout_q <= req_dout_d;
      req_rdy_q  <= req_rdy_d;
      busy_q     <= busy_d;
      mem_a_q    <= mem_a_d;
      mem_rd_q   <= mem_rd_d;
    end
  end

  assign bus_io.req_dout   = req_dout_q;
  assign bus_io.req_rdy    = req_rdy_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.dma_active = dma_q;
  assign bus_io.mem_a      = mem_a_q;
  assign bus_io.mem_rd     = mem_rd_q;
  assign bus_io.ri_sel     = ri_sel_q;
  assign bus_io.ri_ncs     = ri_ncs_q;
  assign bus_io.ri_r_nw    = ri_r_nw_q;
  assign bus_io.ri_din     = ri_din_q;

endmodule

// File: tb/tb_ppu_ri_master.sv
// Directed and randomized checks of ppu_ri_master against a cycle-count model of
// PPU windows, completions, sprite DMA and asynchronous reset.
module tb_ppu_ri_master;
  localparam int unsigned L = 4;
  localparam int unsigned H = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ppu_ri_master_if bus ();

  ppu_ri_master #(
    .CS_LOW_CYCLES (L),
    .CS_HIGH_CYCLES(H)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  logic [7:0] mem [0:65535];
  logic [7:0] ppu_val = 8'h00;

  // PPU only drives meaningful data while selected.
  assign bus.ri_dout = bus.ri_ncs ? 8'hEE : ppu_val;
  always @(posedge clk) if (bus.mem_rd) bus.mem_din <= mem[bus.mem_a];

  int checks = 0;
  int errors = 0;

  // Observations of the last operation.
  int low_cnt, falls, rdy_cnt, rdy_cyc, busy_last, dma_first, dma_last, rd_cnt, bad_mem;
  int unstable;
  logic [7:0]  dout_at_rdy;
  logic [11:0] win_q[$];
  logic [7:0]  page_m;

  // Expected register state held by the DUT.
  logic [2:0] m_sel  = 3'd0;
  logic       m_rnw  = 1'b1;
  logic [7:0] m_din  = 8'h00;
  logic [7:0] m_dout = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request accepted at the edge ending cycle 0, then observe cycles 1..ncyc.
  // A second req pulse is driven over the edge ending cycle pulse_at (0 = none).
  task automatic run_op(input logic [15:0] a, input logic rnw, input logic [7:0] din,
                        input int ncyc, input int pulse_at);
    logic        prev_ncs;
    logic [11:0] cur;
    low_cnt = 0; falls = 0; rdy_cnt = 0; rdy_cyc = 0; busy_last = 0;
    dma_first = 0; dma_last = 0; rd_cnt = 0; bad_mem = 0; unstable = 0;
    dout_at_rdy = bus.req_dout;
    win_q.delete();
    prev_ncs = 1'b1;
    cur = '0;
    @(negedge clk);
    bus.req = 1'b1; bus.req_a = a; bus.req_r_nw = rnw; bus.req_din = din;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (!bus.ri_ncs) begin
        low_cnt++;
        if (prev_ncs) begin
          falls++;
          cur = {bus.ri_sel, bus.ri_r_nw, bus.ri_din};
          win_q.push_back(cur);
        end else if ({bus.ri_sel, bus.ri_r_nw, bus.ri_din} != cur) begin
          unstable++;
        end
      end
      prev_ncs = bus.ri_ncs;
      if (bus.req_rdy) begin rdy_cnt++; rdy_cyc = k; dout_at_rdy = bus.req_dout; end
      if (bus.busy) busy_last = k;
      if (bus.dma_active) begin
        if (dma_first == 0) dma_first = k;
        dma_last = k;
      end
      if (bus.mem_rd) begin
        if (bus.mem_a !== {page_m, rd_cnt[7:0]}) bad_mem++;
        rd_cnt++;
      end
      bus.req = (k == pulse_at);
    end
    bus.req = 1'b0;
  endtask

  task automatic check_op(input string tag, input int exp_win, input int exp_rdy_cnt,
                          input int exp_rdy_cyc, input int exp_busy_last);
    check({tag, ".windows"}, falls, exp_win);
    check({tag, ".low_clks"}, low_cnt, exp_win * L);
    check({tag, ".rdy_count"}, rdy_cnt, exp_rdy_cnt);
    check({tag, ".rdy_cycle"}, rdy_cyc, exp_rdy_cyc);
    check({tag, ".busy_last"}, busy_last, exp_busy_last);
    check({tag, ".dout"}, dout_at_rdy, m_dout);
    check({tag, ".stable"}, unstable, 0);
    check({tag, ".held"}, {bus.ri_sel, bus.ri_r_nw, bus.ri_din}, {m_sel, m_rnw, m_din});
    if (exp_win > 0) check({tag, ".last_win"}, win_q[$], {m_sel, m_rnw, m_din});
  endtask

  // Watch n cycles for any activity; reset (if held) is released at cycle rel.
  task automatic idle_watch(input string tag, input int n, input int rel);
    int lows = 0;
    int act = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (!bus.ri_ncs) lows++;
      if (bus.mem_rd || bus.req_rdy || bus.busy || bus.dma_active) act++;
      if (k == rel) rst = 1'b0;
    end
    check({tag, ".ncs_low"}, lows, 0);
    check({tag, ".activity"}, act, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [15:0] a;
    logic        rnw;
    logic [7:0]  din;
    int          bad_win;
    bus.req = 1'b0; bus.req_a = '0; bus.req_r_nw = 1'b1; bus.req_din = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int n = 0; n < 256; n++) mem[16'h0200 + n] = 8'(n) ^ 8'hA5;

    // Reset acts before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst.ncs", bus.ri_ncs, 1'b1);
    check("rst.rnw", bus.ri_r_nw, 1'b1);
    check("rst.sel", bus.ri_sel, 3'd0);
    check("rst.din", bus.ri_din, 8'h00);
    check("rst.rdy", bus.req_rdy, 1'b0);
    check("rst.dout", bus.req_dout, 8'h00);
    check("rst.busy", bus.busy, 1'b0);
    check("rst.dma", bus.dma_active, 1'b0);
    check("rst.mem_rd", bus.mem_rd, 1'b0);
    check("rst.mem_a", bus.mem_a, 16'h0000);
    idle_watch("rst_release", 4, 2);

    // PPU write.
    run_op(16'h2006, 1'b0, 8'h3F, L + H + 4, 0);
    m_sel = 3'd6; m_rnw = 1'b0; m_din = 8'h3F;
    check_op("wr2006", 1, 1, L + 1, L + H);

    // Mirrored read.
    ppu_val = 8'h80;
    run_op(16'h3FFA, 1'b1, 8'h00, L + H + 4, 0);
    m_sel = 3'd2; m_rnw = 1'b1; m_din = 8'h00; m_dout = 8'h80;
    check_op("rd3ffa", 1, 1, L + 1, L + H);

    // Null access.
    run_op(16'h4016, 1'b1, 8'h00, 4, 0);
    m_dout = 8'h00;
    check_op("null4016", 0, 1, 1, 0);

    // Request during CS_LOW is dropped; so is one on the last busy clock.
    run_op(16'h2001, 1'b0, 8'h5C, 2 * (L + H) + 6, 2);
    m_sel = 3'd1; m_rnw = 1'b0; m_din = 8'h5C;
    check_op("drop_cslow", 1, 1, L + 1, L + H);
    run_op(16'h2001, 1'b0, 8'h5C, 2 * (L + H) + 6, L + H);
    check_op("drop_lastbusy", 1, 1, L + 1, L + H);

    // Request in the cycle busy falls is accepted.
    run_op(16'h2007, 1'b0, 8'h11, 2 * (L + H) + 6, L + H + 1);
    m_sel = 3'd7; m_rnw = 1'b0; m_din = 8'h11;
    check_op("b2b", 2, 2, (L + H + 1) + L + 1, 2 * (L + H) + 1);

    // Full sprite DMA from page 2.
    page_m = 8'h02;
    run_op(16'h4014, 1'b0, 8'h02, 256 * (L + H + 2) + 6, 0);
    m_sel = 3'd4; m_rnw = 1'b0; m_din = mem[16'h02FF];
    check_op("dma", 256, 1, 256 * (L + H + 2), 256 * (L + H + 2));
    check("dma.first_active", dma_first, 1);
    check("dma.last_active", dma_last, 256 * (L + H + 2));
    check("dma.reads", rd_cnt, 256);
    check("dma.addr", bad_mem, 0);
    bad_win = 0;
    for (int n = 0; n < win_q.size(); n++)
      if (win_q[n] !== {3'd4, 1'b0, 8'(n) ^ 8'hA5}) bad_win++;
    check("dma.data", bad_win, 0);
    check("dma.active_after", bus.dma_active, 1'b0);

    // Reset in the low window of DMA byte 17.
    page_m = 8'($urandom_range(0, 255));
    run_op(16'h4014, 1'b0, page_m, 17 * (L + H + 2) + 3, 0);
    check("dmarst.reads", rd_cnt, 18);
    check("dmarst.windows", falls, 18);
    check("dmarst.addr", bad_mem, 0);
    check("dmarst.ncs_before", bus.ri_ncs, 1'b0);
    rst = 1'b1;
    #1;
    check("dmarst.ncs", bus.ri_ncs, 1'b1);
    check("dmarst.dma", bus.dma_active, 1'b0);
    check("dmarst.busy", bus.busy, 1'b0);
    check("dmarst.rdy", bus.req_rdy, 1'b0);
    check("dmarst.mem_rd", bus.mem_rd, 1'b0);
    check("dmarst.sel", bus.ri_sel, 3'd0);
    m_sel = 3'd0; m_rnw = 1'b1; m_din = 8'h00; m_dout = 8'h00;
    idle_watch("dmarst_quiet", 20, 3);
    din = 8'($urandom);
    run_op(16'h2001, 1'b0, din, L + H + 4, 0);
    m_sel = 3'd1; m_rnw = 1'b0; m_din = din;
    check_op("after_rst", 1, 1, L + 1, L + H);

    // Random PPU and null accesses.
    for (int i = 0; i < 24; i++) begin
      a   = 16'($urandom);
      rnw = 1'($urandom);
      din = 8'($urandom);
      ppu_val = 8'($urandom);
      if ($urandom_range(0, 1) == 1) a = 16'h2000 + 16'($urandom_range(0, 16'h1FFF));
      if (a == 16'h4014) rnw = 1'b1;
      run_op(a, rnw, din, L + H + 3, 0);
      if (a >= 16'h2000 && a <= 16'h3FFF) begin
        m_sel = 3'(a % 8); m_rnw = rnw; m_din = din;
        if (rnw) m_dout = ppu_val;
        check_op("rand_ppu", 1, 1, L + 1, L + H);
      end else begin
        m_dout = 8'h00;
        check_op("rand_null", 0, 1, 1, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ppu_ri_master.md
PPU_RI_MASTER -- requirements
Module: ppu_ri_master

Interface
REQ-001 SHALL have parameter CS_LOW_CYCLES, default 4: clocks ri_ncs is held low per PPU access (legal range 2-15).
REQ-002 SHALL have parameter CS_HIGH_CYCLES, default 2: minimum clocks ri_ncs is held high after each access (legal range 1-15).
REQ-003 SHALL have port clk, input, 1: system clock; the block uses one clock.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port req, input, 1: CPU access request, sampled only while busy=0.
REQ-006 SHALL have port req_a, input, 16: CPU address.
REQ-007 SHALL have port req_r_nw, input, 1: 1 = read, 0 = write.
REQ-008 SHALL have port req_din, input, 8: CPU write data.
REQ-009 SHALL have port req_dout, output, 8: read data, valid when req_rdy=1 and held until the next completion.
REQ-010 SHALL have port req_rdy, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port busy, output, 1: high from the cycle after acceptance until the block returns to IDLE.
REQ-012 SHALL have port dma_active, output, 1: high while a sprite DMA is running.
REQ-013 SHALL have port mem_a, output, 16: DMA source address.
REQ-014 SHALL have port mem_rd, output, 1: DMA read strobe.
REQ-015 SHALL have port mem_din, input, 8: DMA read data, valid the cycle after mem_rd.
REQ-016 SHALL have port ri_sel, output, 3: PPU register select.
REQ-017 SHALL have port ri_ncs, output, 1: PPU chip select, active low.
REQ-018 SHALL have port ri_r_nw, output, 1: PPU read/write select.
REQ-019 SHALL have port ri_din, output, 8: data to the PPU.
REQ-020 SHALL have port ri_dout, input, 8: data from the PPU, valid only while ri_ncs=0.

Function
REQ-021 SHALL decode the address accepted on req && !busy as follows:
- 0x2000-0x3FFF: PPU access, with ri_sel = req_a[2:0] (mirrored every 8 bytes).
- 0x4014 write: sprite DMA, with page = req_din.
- Any other address: null access.
REQ-022 SHALL, for a null access, pulse req_rdy the cycle after acceptance with req_dout=0x00, leave ri_* unchanged and leave busy low.
REQ-023 SHALL use the states IDLE, CS_LOW, CS_HIGH, DMA_RD and DMA_CAP.
- PPU access: IDLE -> CS_LOW -> CS_HIGH -> IDLE.
- DMA: IDLE -> DMA_RD -> DMA_CAP -> CS_LOW -> CS_HIGH -> DMA_RD, repeating until the final byte, then CS_HIGH -> IDLE.
REQ-024 SHALL register ri_sel, ri_r_nw and ri_din at acceptance and hold them stable through CS_LOW and until the next access.
REQ-025 SHALL drive ri_ncs=0 for exactly CS_LOW_CYCLES clocks, starting the cycle after acceptance (or after DMA_CAP).
REQ-026 SHALL drive ri_ncs=1 for at least CS_HIGH_CYCLES clocks between any two low windows, so every access presents exactly one falling edge to the PPU.
REQ-027 SHALL, for a PPU read, capture ri_dout into req_dout on the last CS_LOW clock.
REQ-028 SHALL, for a CPU-initiated PPU access, pulse req_rdy on the first CS_HIGH clock; for writes, req_dout is unchanged.
REQ-029 SHALL give a default-parameter PPU access this timing: accept at edge 0, ri_ncs low cycles 1-4, req_rdy in cycle 5, busy low again in cycle 7.
REQ-030 SHALL run sprite DMA as follows:
- Per byte n = 0..255: DMA_RD drives mem_rd=1 for one cycle with mem_a={page,n[7:0]}.
- DMA_CAP latches mem_din into ri_din with ri_sel=3'h4, ri_r_nw=0.
- Each byte is then a PPU write window.
REQ-031 SHALL use an 8-bit DMA byte index with a separate done flag, so the index wraps from 255 to 0 without an extra byte; exactly 256 writes are issued.
REQ-032 SHALL assert dma_active from DMA_RD of byte 0 through CS_HIGH of byte 255, and pulse req_rdy once, on the final CS_HIGH clock of byte 255.
REQ-033 SHALL give a default-parameter DMA a length of 256 x 8 = 2048 busy clocks.
REQ-034 SHALL ignore (drop, not queue) req while busy=1; a req asserted in the same cycle that busy falls is accepted.
REQ-035 SHALL hold mem_rd=0 and mem_a unchanged outside DMA_RD.

Reset
REQ-036 SHALL, on rst assertion and without waiting for clk, force:
- ri_ncs=1, ri_r_nw=1, ri_sel=0, ri_din=0x00
- req_rdy=0, req_dout=0x00, busy=0, dma_active=0
- mem_rd=0, mem_a=0x0000
- state IDLE, DMA index 0
REQ-037 SHALL abort any access or DMA in progress on reset with no req_rdy, and shall not generate an ri_ncs falling edge during or on release of reset.

Verification
REQ-038 SHALL cover a PPU write: req_a=0x2006, req_din=0x3F, r_nw=0 -> ri_sel=6, ri_din=0x3F, ri_ncs low cycles 1-4, req_rdy in cycle 5.
REQ-039 SHALL cover a mirrored read: req_a=0x3FFA, r_nw=1, PPU ri_dout=0x80 -> ri_sel=2, req_dout=0x80 with req_rdy.
REQ-040 SHALL cover DMA: write 0x4014=0x02, memory[0x0200+n]=n^0xA5 -> 256 ri writes with sel=4 and data n^0xA5 in order, one req_rdy at cycle 2048, dma_active low afterwards.
REQ-041 SHALL cover busy drop: a second req pulse during CS_LOW -> no second access, exactly one req_rdy.
REQ-042 SHALL cover reset mid-operation: rst asserted at DMA byte 17 -> ri_ncs=1 and dma_active=0 immediately, no further mem_rd or req_rdy, next access behaves per REQ-029.
REQ-043 SHALL cover null access: req_a=0x4016 read -> req_rdy the next cycle, req_dout=0x00, ri_ncs stays 1.
